// File: rtl/led_matrix_editor_if.sv
// Pin bundle between the LED matrix editor and its owner (mode mux / bench).
interface led_matrix_editor_if #(
    parameter int ROWS   = 5,
    parameter int COLS   = 7,
    parameter int FRAMES = 4
);
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic              en;
    logic [4:1]        key;
    logic [ROWS-1:0]   row;
    logic [COLS-1:0]   column;
    logic              edit;
    logic [FW-1:0]     frame_sel;

    // Owner side: enables the block, forwards raw buttons, observes the matrix.
    modport master (output en, key, input row, column, edit, frame_sel);
    // Editor side.
    modport slave  (input en, key, output row, column, edit, frame_sel);
endinterface

// File: rtl/led_matrix_editor.sv
// Multi-frame pixel editor and column scanner for the pocket LED matrix.
// Four debounced buttons edit FRAMES bitmaps of ROWS x COLS pixels; the block
// also scans the selected frame onto the column-multiplexed matrix.
module led_matrix_editor #(
    parameter int ROWS         = 5,
    parameter int COLS         = 7,
    parameter int FRAMES       = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int SCAN_CYC     = 50_000,
    parameter int BLINK_CYC    = 12_500_000,
    parameter int PLAY_CYC     = 25_000_000
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    led_matrix_editor_if.slave bus
);
    localparam int NPIX = ROWS * COLS;
    localparam int CW   = $clog2(NPIX);
    localparam int FW   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int LW   = $clog2(LONG_CYC + 1);
    localparam int SW   = $clog2(SCAN_CYC + 1);
    localparam int BW   = $clog2(BLINK_CYC + 1);
    localparam int PW   = $clog2(PLAY_CYC + 1);

    typedef enum logic [1:0] {K1_IDLE, K1_HELD, K1_LONG} k1_state_e;

    // Key path state: synchroniser, debounced "pressed" level, edge history.
    logic [4:1]    meta_q, meta_d, sync_q, sync_d;
    logic [4:1]    pressed_q, pressed_d;
    logic [4:2]    prev_q, prev_d;
    logic [DW-1:0] deb_cnt_q [4:1];
    logic [DW-1:0] deb_cnt_d [4:1];
    logic [4:2]    press_pulse;

    // key[1] press classifier.
    k1_state_e     k1_state_q, k1_state_d;
    logic [LW-1:0] hold_cnt_q, hold_cnt_d;
    logic          k1_short, k1_long;

    // Editor state.
    logic [NPIX-1:0] frames_q [FRAMES];
    logic [NPIX-1:0] frames_d [FRAMES];
    logic [CW-1:0]   cursor_q, cursor_d;
    logic [FW-1:0]   frame_q, frame_d, frame_next;
    logic            edit_q, edit_d, play_q, play_d;
    logic [PW-1:0]   play_cnt_q, play_cnt_d;

    // Scanner state.
    logic [COLW-1:0] col_q, col_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;
    logic [ROWS-1:0] row_q, row_d;
    logic [COLS-1:0] column_q, column_d;
    logic [CW-1:0]   pix_idx;

    logic ev_short, ev_long, ev_k2, ev_k3, ev_k4;

    // Synchronise, then debounce each key; the level flips after DEBOUNCE_CYC differing cycles.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        meta_d    = bus.key;
        sync_d    = meta_q;
        pressed_d = pressed_q;
        prev_d    = pressed_q[4:2];
        for (int k = 1; k <= 4; k++) begin
            deb_cnt_d[k] = '0;
            if (~sync_q[k] != pressed_q[k]) begin
                if (deb_cnt_q[k] == DW'(DEBOUNCE_CYC - 1)) pressed_d[k] = ~sync_q[k];
                else deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
            end
        end
    end

    assign press_pulse = pressed_q[4:2] & ~prev_q;

    // key[1] FSM: short pulse on release before LONG_CYC, long pulse once when the hold expires.
    always_comb begin
        k1_state_d = k1_state_q;
        hold_cnt_d = hold_cnt_q;
        k1_short   = 1'b0;
        k1_long    = 1'b0;
        case (k1_state_q)
            K1_IDLE: begin
                hold_cnt_d = '0;
                if (pressed_q[1]) k1_state_d = K1_HELD;
            end
            K1_HELD: begin
                if (!pressed_q[1]) begin
                    k1_short   = 1'b1;
                    k1_state_d = K1_IDLE;
                end else if (hold_cnt_q == LW'(LONG_CYC - 1)) begin
                    k1_long    = 1'b1;
                    k1_state_d = K1_LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + LW'(1);
                end
            end
            K1_LONG:  if (!pressed_q[1]) k1_state_d = K1_IDLE;
            default:  k1_state_d = K1_IDLE;
        endcase
    end

    // Key pulses only act while the block is selected; the key path itself keeps running.
    assign ev_short = bus.en & k1_short;
    assign ev_long  = bus.en & k1_long;
    assign ev_k2    = bus.en & press_pulse[2];
    assign ev_k3    = bus.en & press_pulse[3];
    assign ev_k4    = bus.en & press_pulse[4];
    assign frame_next = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);

    // Editor: all same-cycle events read pre-update state; clear is applied after toggle so it wins.
    always_comb begin
        frames_d   = frames_q;
        cursor_d   = cursor_q;
        edit_d     = edit_q;
        play_d     = play_q;
        frame_d    = frame_q;
        play_cnt_d = play_cnt_q;
        if (ev_short && edit_q)
            cursor_d = (cursor_q == CW'(NPIX - 1)) ? '0 : cursor_q + CW'(1);
        if (ev_k2 && edit_q)
            frames_d[frame_q][cursor_q] = ~frames_q[frame_q][cursor_q];
        if (ev_k4 && edit_q)
            frames_d[frame_q] = '0;
        if (ev_k4 && !edit_q)
            play_d = ~play_q;
        if (ev_long) begin
            edit_d = ~edit_q;
            if (!edit_q) play_d = 1'b0;
        end
        if (bus.en) begin
            if (ev_k3) begin
                frame_d    = frame_next;
                play_cnt_d = '0;
            end else if (play_q && !edit_q) begin
                if (play_cnt_q == PW'(PLAY_CYC - 1)) begin
                    frame_d    = frame_next;
                    play_cnt_d = '0;
                end else begin
                    play_cnt_d = play_cnt_q + PW'(1);
                end
            end else begin
                play_cnt_d = '0;
            end
        end
    end

    // Scanner: column index and blink phase advance only while enabled; outputs are registered.
    always_comb begin
        col_d       = col_q;
        scan_cnt_d  = scan_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        column_d    = '0;
        row_d       = '0;
        pix_idx     = '0;
        if (bus.en) begin
            if (scan_cnt_q == SW'(SCAN_CYC - 1)) begin
                scan_cnt_d = '0;
                col_d      = (col_q == COLW'(COLS - 1)) ? '0 : col_q + COLW'(1);
            end else begin
                scan_cnt_d = scan_cnt_q + SW'(1);
            end
            if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
            column_d[col_q] = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                pix_idx  = CW'(int'(col_q) * ROWS + r);
                row_d[r] = frames_q[frame_q][pix_idx] ^ (edit_q && blink_q && (cursor_q == pix_idx));
            end
        end
    end

    // Key path registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            meta_q     <= '1;
            sync_q     <= '1;
            pressed_q  <= '0;
            prev_q     <= '0;
            deb_cnt_q  <= '{default: '0};
            k1_state_q <= K1_IDLE;
            hold_cnt_q <= '0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            pressed_q  <= pressed_d;
            prev_q     <= prev_d;
            deb_cnt_q  <= deb_cnt_d;
            k1_state_q <= k1_state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Editor registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            // NOTE: frame storage is built from flops rather than RAM because reset must clear every frame.
            frames_q   <= '{default: '0};
            cursor_q   <= '0;
            edit_q     <= 1'b0;
            play_q     <= 1'b0;
            frame_q    <= '0;
            play_cnt_q <= '0;
        end else begin
            frames_q   <= frames_d;
            cursor_q   <= cursor_d;
            edit_q     <= edit_d;
            play_q     <= play_d;
            frame_q    <= frame_d;
            play_cnt_q <= play_cnt_d;
        end
    end

    // Scanner registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            row_q       <= '0;
            column_q    <= '0;
        end else begin
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            row_q       <= row_d;
            column_q    <= column_d;
        end
    end

    assign bus.row       = row_q;
    assign bus.column    = column_q;
    assign bus.edit      = edit_q;
    assign bus.frame_sel = frame_q;
endmodule

// File: tb/tb_led_matrix_editor.sv
// Self-checking bench for led_matrix_editor with small timing parameters.
// The reference model tracks pixels, cursor, frame and mode per accepted key
// event, and derives scan column and blink phase from a count of enabled edges.
module tb_led_matrix_editor;
    localparam int ROWS = 5, COLS = 7, FRAMES = 4;
    localparam int DEB = 4, LONG = 40, SCAN = 2, BLINK = 16, PLAY = 100;
    localparam int NPIX = ROWS * COLS;

    logic CLOCK_50 = 1'b0;
    logic rst;

    led_matrix_editor_if #(.ROWS(ROWS), .COLS(COLS), .FRAMES(FRAMES)) bus ();

    led_matrix_editor #(
        .ROWS(ROWS), .COLS(COLS), .FRAMES(FRAMES), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG),
        .SCAN_CYC(SCAN), .BLINK_CYC(BLINK), .PLAY_CYC(PLAY)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model.
    bit [NPIX-1:0] m_frames [FRAMES];
    int            m_cursor, m_frame, en_edges, last_blink;
    bit            m_edit, m_play, quiet;
    logic [COLS-1:0] exp_col;
    logic [ROWS-1:0] exp_row;
    int total, bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROWS-1:0] model_row(input int c, input int blink);
        logic [ROWS-1:0] r;
        for (int i = 0; i < ROWS; i++) begin
            r[i] = m_frames[m_frame][c * ROWS + i];
            if (m_edit && blink == 1 && m_cursor == c * ROWS + i) r[i] = ~r[i];
        end
        return r;
    endfunction

    // One clock: predict the registered scan outputs, then compare on the falling edge.
    task automatic tick();
        @(posedge CLOCK_50);
        if (bus.en) begin
            exp_col    = COLS'(1) << ((en_edges / SCAN) % COLS);
            last_blink = (en_edges / BLINK) % 2;
            exp_row    = model_row((en_edges / SCAN) % COLS, last_blink);
            en_edges++;
        end else begin
            exp_col = '0;
            exp_row = '0;
        end
        @(negedge CLOCK_50);
        chk("column", 32'(bus.column), 32'(exp_col));
        if (quiet) chk("row", 32'(bus.row), 32'(exp_row));
    endtask

    task automatic model_reset();
        for (int f = 0; f < FRAMES; f++) m_frames[f] = '0;
        m_cursor = 0; m_frame = 0; m_edit = 0; m_play = 0;
        en_edges = 0; exp_col = '0; exp_row = '0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_column", 32'(bus.column), 32'd0);
        chk("rst_row", 32'(bus.row), 32'd0);
        chk("rst_edit", 32'(bus.edit), 32'd0);
        chk("rst_frame", 32'(bus.frame_sel), 32'd0);
        #1 rst = 1'b0;
    endtask

    // Clean press of key k for len cycles, then enough idle time for all effects to land.
    task automatic press(input int k, input int len);
        quiet = 1'b0;
        bus.key[k] = 1'b0;
        repeat (len) tick();
        bus.key[k] = 1'b1;
        repeat (12) tick();
    endtask

    task automatic short1();
        press(1, $urandom_range(6, 18));
        if (m_edit) m_cursor = (m_cursor + 1) % NPIX;
        quiet = 1'b1;
    endtask

    task automatic long1();
        press(1, 60);
        if (!m_edit) m_play = 0;
        m_edit = ~m_edit;
        quiet = 1'b1;
    endtask

    task automatic key2();
        press(2, $urandom_range(6, 18));
        if (m_edit) m_frames[m_frame][m_cursor] = ~m_frames[m_frame][m_cursor];
        quiet = 1'b1;
    endtask

    task automatic key3();
        press(3, $urandom_range(6, 18));
        m_frame = (m_frame + 1) % FRAMES;
        quiet = 1'b1;
    endtask

    task automatic key4();
        press(4, $urandom_range(6, 18));
        if (m_edit) m_frames[m_frame] = '0;
        else m_play = ~m_play;
        quiet = 1'b1;
    endtask

    task automatic goto_cursor(input int target);
        while (m_cursor != target) short1();
    endtask

    initial begin
        int waited;
        int tgt;
        total = 0; bad = 0; quiet = 1'b1;
        bus.en = 1'b1; bus.key = '1; rst = 1'b0;
        model_reset();

        // 1. Reset, then a clean scan walk with blank rows.
        do_reset();
        repeat (30) tick();
        chk("view_edit", 32'(bus.edit), 32'd0);
        chk("view_frame", 32'(bus.frame_sel), 32'd0);

        // 2. key[1] bounces shorter than the debounce window produce nothing.
        quiet = 1'b0;
        repeat (4) begin
            bus.key[1] = 1'b0;
            repeat ($urandom_range(1, DEB - 1)) tick();
            bus.key[1] = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
        end
        repeat (12) tick();
        quiet = 1'b1;
        chk("bounce_edit", 32'(bus.edit), 32'd0);
        long1();
        chk("long_edit", 32'(bus.edit), 32'd1);
        repeat (40) tick();
        short1();
        repeat (40) tick();

        // 3. Cursor wrap, pixel toggle, frame clear.
        goto_cursor(NPIX - 1);
        short1();
        chk("cursor_wrap_edit", 32'(bus.edit), 32'd1);
        repeat (40) tick();
        goto_cursor(7);
        key2();
        waited = 0;
        while (!(exp_col == COLS'(2) && last_blink == 0) && waited < 200) begin
            tick();
            waited++;
        end
        chk("pix7_timeout", 32'(waited < 200), 32'd1);
        chk("pix7_row2", 32'(bus.row[2]), 32'd1);
        repeat (3) begin
            tgt = $urandom_range(0, NPIX - 1);
            goto_cursor(tgt);
            key2();
            repeat (20) tick();
        end
        key4();
        repeat (60) tick();

        // 4. Frames: a pixel in frame 0 survives a full cycle through the others.
        goto_cursor(12);
        key2();
        key3();
        chk("frame_one", 32'(bus.frame_sel), 32'd1);
        repeat (40) tick();
        repeat (3) key3();
        chk("frame_back", 32'(bus.frame_sel), 32'd0);
        repeat (60) tick();

        // 5. Autoplay in view mode: one step every PLAY cycles with wrap; a long press stops it.
        long1();
        chk("view_again", 32'(bus.edit), 32'd0);
        key4();
        quiet = 1'b0;
        waited = 0;
        while (32'(bus.frame_sel) == 32'(m_frame) && waited < 150) begin
            tick();
            waited++;
        end
        chk("play_timeout", 32'(waited < 150), 32'd1);
        m_frame = (m_frame + 1) % FRAMES;
        chk("play_first", 32'(bus.frame_sel), 32'(m_frame));
        for (int s = 0; s < 5; s++) begin
            repeat (PLAY - 1) begin
                tick();
                chk("play_hold", 32'(bus.frame_sel), 32'(m_frame));
            end
            tick();
            m_frame = (m_frame + 1) % FRAMES;
            chk("play_step", 32'(bus.frame_sel), 32'(m_frame));
        end
        long1();
        chk("play_edit", 32'(bus.edit), 32'd1);
        repeat (150) begin
            tick();
            chk("play_stopped", 32'(bus.frame_sel), 32'(m_frame));
        end

        // 6. Disable mid-scan: outputs blank, key ignored, scan resumes where it stopped.
        repeat ($urandom_range(1, 5)) tick();
        bus.en = 1'b0;
        repeat (10) tick();
        key2();
        if (m_edit) m_frames[m_frame][m_cursor] = ~m_frames[m_frame][m_cursor];
        repeat (5) tick();
        bus.en = 1'b1;
        repeat (30) tick();
        // key[1] pressed while disabled, released after enable, still counts as short.
        bus.en = 1'b0;
        quiet = 1'b0;
        bus.key[1] = 1'b0;
        repeat (10) tick();
        bus.en = 1'b1;
        repeat (4) tick();
        bus.key[1] = 1'b1;
        repeat (12) tick();
        m_cursor = (m_cursor + 1) % NPIX;
        quiet = 1'b1;
        repeat (40) tick();

        // Reset in the middle of a hold.
        quiet = 1'b0;
        bus.key[1] = 1'b0;
        repeat (20) tick();
        do_reset();
        repeat (10) tick();
        bus.key[1] = 1'b1;
        repeat (12) tick();
        quiet = 1'b1;
        repeat (30) tick();
        chk("final_edit", 32'(bus.edit), 32'd0);
        chk("final_frame", 32'(bus.frame_sel), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
